// File: rtl/control_unit.sv
// Main decoder for the ID stage of a 5-stage MIPS32 pipeline.
// Maps Opcode/Funct to datapath controls, resolves beq/bne from the
// register comparator and drives PC select plus IF flush for redirects.
// Purely combinational; Clock exists only to match the pipeline port set.
module control_unit (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Cmp_RsRt,
    output logic [1:0] PCSrc,
    output logic       IF_Flush,
    output logic       Branch,
    output logic       SignExt,
    output logic       NoDest,
    output logic [2:0] ALUCtrl,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite
);

    // Opcode encodings
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_R2    = 6'b011100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Funct encodings
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MUL   = 6'b000010;

    // ALU operations
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;
    localparam logic [2:0] ALU_DIV  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SHL  = 3'b110;
    localparam logic [2:0] ALU_MFHI = 3'b111;

    // PC select
    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_JMP   = 2'b10;
    localparam logic [1:0] PC_RS    = 2'b11;

    // Clock carries no state; tie it off so it is visibly intentional.
    logic clock_unused;
    assign clock_unused = Clock;

    // Decode: NOP vector by default, overridden per recognised instruction
    always_comb begin
        PCSrc    = PC_SEQ;
        IF_Flush = 1'b0;
        Branch   = 1'b0;
        SignExt  = 1'b0;
        NoDest   = 1'b1;
        ALUCtrl  = ALU_ADD;
        ALUSrc   = 1'b0;
        RegDst   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;

        if (Reset_n) begin
            unique case (Opcode)
                OP_R: begin
                    unique case (Funct)
                        FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_MFHI: begin
                            RegDst   = 1'b1;
                            RegWrite = 1'b1;
                            NoDest   = 1'b0;
                            unique case (Funct)
                                FN_ADD:  ALUCtrl = ALU_ADD;
                                FN_SUB:  ALUCtrl = ALU_SUB;
                                FN_SLL:  ALUCtrl = ALU_SHL;
                                FN_SLT:  ALUCtrl = ALU_SLT;
                                default: ALUCtrl = ALU_MFHI;
                            endcase
                        end
                        // div only updates HI/LO
                        FN_DIV: begin
                            ALUCtrl = ALU_DIV;
                        end
                        FN_JR: begin
                            PCSrc    = PC_RS;
                            IF_Flush = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_R2: begin
                    if (Funct == FN_MUL) begin
                        ALUCtrl  = ALU_MUL;
                        RegDst   = 1'b1;
                        RegWrite = 1'b1;
                        NoDest   = 1'b0;
                    end
                end
                OP_ADDI: begin
                    ALUCtrl  = ALU_ADD;
                    ALUSrc   = 1'b1;
                    SignExt  = 1'b1;
                    RegWrite = 1'b1;
                    NoDest   = 1'b0;
                end
                OP_ORI: begin
                    ALUCtrl  = ALU_OR;
                    ALUSrc   = 1'b1;
                    RegWrite = 1'b1;
                    NoDest   = 1'b0;
                end
                // ALU shifts the zero-extended immediate by 16 when ALUSrc=1
                OP_LUI: begin
                    ALUCtrl  = ALU_SHL;
                    ALUSrc   = 1'b1;
                    RegWrite = 1'b1;
                    NoDest   = 1'b0;
                end
                OP_LW: begin
                    ALUCtrl  = ALU_ADD;
                    ALUSrc   = 1'b1;
                    SignExt  = 1'b1;
                    MemRead  = 1'b1;
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    NoDest   = 1'b0;
                end
                OP_SW: begin
                    ALUCtrl  = ALU_ADD;
                    ALUSrc   = 1'b1;
                    SignExt  = 1'b1;
                    MemWrite = 1'b1;
                end
                // Branches resolve in ID: beq taken on equal, bne on not-equal
                OP_BEQ, OP_BNE: begin
                    Branch  = 1'b1;
                    SignExt = 1'b1;
                    ALUCtrl = ALU_SUB;
                    if ((Opcode == OP_BEQ) ? Cmp_RsRt : !Cmp_RsRt) begin
                        PCSrc    = PC_BR;
                        IF_Flush = 1'b1;
                    end
                end
                OP_J: begin
                    PCSrc    = PC_JMP;
                    IF_Flush = 1'b1;
                end
                // Datapath substitutes $31 and PC+8 for the link write
                OP_JAL: begin
                    PCSrc    = PC_JMP;
                    IF_Flush = 1'b1;
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    NoDest   = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a vector table of decodes, an opcode
// sweep for unlisted encodings, and an asynchronous reset sequence.
module tb_control_unit;

    logic       Clock;
    logic       Reset_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Cmp_RsRt;
    logic [1:0] PCSrc;
    logic       IF_Flush;
    logic       Branch;
    logic       SignExt;
    logic       NoDest;
    logic [2:0] ALUCtrl;
    logic       ALUSrc;
    logic       RegDst;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       RegWrite;

    int tests_run;
    int tests_failed;

    control_unit dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Opcode   (Opcode),
        .Funct    (Funct),
        .Cmp_RsRt (Cmp_RsRt),
        .PCSrc    (PCSrc),
        .IF_Flush (IF_Flush),
        .Branch   (Branch),
        .SignExt  (SignExt),
        .NoDest   (NoDest),
        .ALUCtrl  (ALUCtrl),
        .ALUSrc   (ALUSrc),
        .RegDst   (RegDst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite)
    );

    // Slow clock so combinational checks fit between edges
    initial Clock = 1'b0;
    always #50 Clock = ~Clock;

    // Packed expected/actual layout:
    // {PCSrc[1:0], IF_Flush, Branch, SignExt, NoDest, ALUCtrl[2:0],
    //  ALUSrc, RegDst, MemRead, MemWrite, MemtoReg, RegWrite}
    typedef logic [14:0] ctl_t;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] fn;
        logic       cmp;
        ctl_t       exp;
    } vec_t;

    function automatic ctl_t mk(input logic [1:0] pc, input logic fl, input logic br,
                                input logic se, input logic nd, input logic [2:0] alu,
                                input logic src, input logic rd, input logic mr,
                                input logic mw, input logic m2r, input logic rw);
        return {pc, fl, br, se, nd, alu, src, rd, mr, mw, m2r, rw};
    endfunction

    function automatic ctl_t actual();
        return {PCSrc, IF_Flush, Branch, SignExt, NoDest, ALUCtrl,
                ALUSrc, RegDst, MemRead, MemWrite, MemtoReg, RegWrite};
    endfunction

    task automatic check(input string name, input ctl_t exp);
        ctl_t act;
        act = actual();
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic [5:0] op,
                         input logic [5:0] fn, input logic cmp);
        Reset_n  = rst_n;
        Opcode   = op;
        Funct    = fn;
        Cmp_RsRt = cmp;
        #1;
    endtask

    vec_t vecs[$];
    ctl_t nop;
    ctl_t lw_vec;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        nop    = mk(2'b00, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0);
        lw_vec = mk(2'b00, 0, 0, 1, 0, 3'b000, 1, 0, 1, 0, 1, 1);

        //            name           rst  op         fn         cmp  expected
        vecs.push_back('{"reset",    0, 6'b000000, 6'b100000, 0, nop});
        vecs.push_back('{"add",      1, 6'b000000, 6'b100000, 0, mk(2'b00,0,0,0,0,3'b000,0,1,0,0,0,1)});
        vecs.push_back('{"add_cmp1", 1, 6'b000000, 6'b100000, 1, mk(2'b00,0,0,0,0,3'b000,0,1,0,0,0,1)});
        vecs.push_back('{"sub",      1, 6'b000000, 6'b100010, 0, mk(2'b00,0,0,0,0,3'b001,0,1,0,0,0,1)});
        vecs.push_back('{"sll",      1, 6'b000000, 6'b000000, 0, mk(2'b00,0,0,0,0,3'b110,0,1,0,0,0,1)});
        vecs.push_back('{"slt",      1, 6'b000000, 6'b101010, 0, mk(2'b00,0,0,0,0,3'b101,0,1,0,0,0,1)});
        vecs.push_back('{"mfhi",     1, 6'b000000, 6'b010000, 0, mk(2'b00,0,0,0,0,3'b111,0,1,0,0,0,1)});
        vecs.push_back('{"div",      1, 6'b000000, 6'b011010, 0, mk(2'b00,0,0,0,1,3'b011,0,0,0,0,0,0)});
        vecs.push_back('{"jr",       1, 6'b000000, 6'b001000, 1, mk(2'b11,1,0,0,1,3'b000,0,0,0,0,0,0)});
        vecs.push_back('{"mul",      1, 6'b011100, 6'b000010, 0, mk(2'b00,0,0,0,0,3'b010,0,1,0,0,0,1)});
        vecs.push_back('{"r2_bad",   1, 6'b011100, 6'b000000, 0, nop});
        vecs.push_back('{"addi",     1, 6'b001000, 6'b000000, 0, mk(2'b00,0,0,1,0,3'b000,1,0,0,0,0,1)});
        vecs.push_back('{"ori",      1, 6'b001101, 6'b111111, 1, mk(2'b00,0,0,0,0,3'b100,1,0,0,0,0,1)});
        vecs.push_back('{"lui",      1, 6'b001111, 6'b000000, 0, mk(2'b00,0,0,0,0,3'b110,1,0,0,0,0,1)});
        vecs.push_back('{"lw",       1, 6'b100011, 6'b000000, 0, lw_vec});
        vecs.push_back('{"sw",       1, 6'b101011, 6'b000000, 1, mk(2'b00,0,0,1,1,3'b000,1,0,0,1,0,0)});
        vecs.push_back('{"beq_nt",   1, 6'b000100, 6'b000000, 0, mk(2'b00,0,1,1,1,3'b001,0,0,0,0,0,0)});
        vecs.push_back('{"beq_t",    1, 6'b000100, 6'b000000, 1, mk(2'b01,1,1,1,1,3'b001,0,0,0,0,0,0)});
        vecs.push_back('{"bne_t",    1, 6'b000101, 6'b000000, 0, mk(2'b01,1,1,1,1,3'b001,0,0,0,0,0,0)});
        vecs.push_back('{"bne_nt",   1, 6'b000101, 6'b000000, 1, mk(2'b00,0,1,1,1,3'b001,0,0,0,0,0,0)});
        vecs.push_back('{"j",        1, 6'b000010, 6'b000000, 0, mk(2'b10,1,0,0,1,3'b000,0,0,0,0,0,0)});
        vecs.push_back('{"jal",      1, 6'b000011, 6'b000000, 1, mk(2'b10,1,0,0,0,3'b000,0,1,0,0,0,1)});
        vecs.push_back('{"op_3f",    1, 6'b111111, 6'b100000, 1, nop});
        vecs.push_back('{"r_fn_3f",  1, 6'b000000, 6'b111111, 1, nop});
        vecs.push_back('{"rst_beq",  0, 6'b000100, 6'b000000, 1, nop});

        // Table-driven decode checks
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].op, vecs[i].fn, vecs[i].cmp);
            check(vecs[i].name, vecs[i].exp);
        end

        // Unlisted opcodes must decode to NOP regardless of funct/cmp
        for (int op = 0; op < 64; op++) begin
            logic [5:0] o;
            o = 6'(op);
            if (!(o inside {6'h00, 6'h1c, 6'h08, 6'h0d, 6'h0f, 6'h23,
                            6'h2b, 6'h04, 6'h05, 6'h02, 6'h03})) begin
                drive(1'b1, o, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
                check($sformatf("unlisted_op_%02h", o), nop);
            end
        end

        // Asynchronous reset with lw held: align just after a rising edge so
        // no Clock edge occurs between driving and sampling.
        drive(1'b1, 6'b100011, 6'b000000, 1'b0);
        @(posedge Clock);
        #5;
        check("lw_before_rst", lw_vec);
        Reset_n = 1'b0;
        #1;
        check("rst_async_nop", nop);
        Reset_n = 1'b1;
        #1;
        check("lw_restored", lw_vec);

        // Branch outcome follows Cmp_RsRt changes with no clock involvement
        drive(1'b1, 6'b000100, 6'b000000, 1'b1);
        check("beq_t_seq", mk(2'b01,1,1,1,1,3'b001,0,0,0,0,0,0));
        Cmp_RsRt = 1'b0;
        #1;
        check("beq_drop_cmp", mk(2'b00,0,1,1,1,3'b001,0,0,0,0,0,0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
